// File: rtl/sram_fifo_ctrl_if.sv
// Push and pop stream bundle for sram_fifo_ctrl.
// The master drives pushes and pop-ready. The slave (the FIFO) drives in_ready and the registered head.
interface sram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller that owns the single port of a 16x8 SRAM, plus a one-entry output register (capacity DEPTH+1).
// Define SRAM_FIFO_FLUSH_EN to add a synchronous 'flush' input that clears the FIFO.
module sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef SRAM_FIFO_FLUSH_EN
  input  logic                  flush,
`endif
  sram_fifo_ctrl_if.slave       sif,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_write_en,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam logic [ADDR_WIDTH:0] MEM_FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_mem_count;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;

  logic w_flush;
  logic w_mem_empty;
  logic w_pop;
  logic w_slot_free;
  logic w_fetch;
  logic w_bypass;
  logic w_in_ready;
  logic w_push;
  logic w_write;

`ifdef SRAM_FIFO_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // A read of the SRAM always wins the single port.
  // Writes therefore only happen while the output register is held.
  assign w_mem_empty = (r_mem_count == '0);
  assign w_pop       = r_out_valid & sif.out_ready;
  assign w_slot_free = ~r_out_valid | w_pop;
  assign w_fetch     = w_slot_free & ~w_mem_empty & ~w_flush;
  assign w_bypass    = w_slot_free & w_mem_empty;
  assign w_in_ready  = ~reset & ~w_flush &
                       (w_bypass | ((r_mem_count != MEM_FULL) & ~w_fetch));
  assign w_push      = sif.in_valid & w_in_ready;
  assign w_write     = w_push & ~w_bypass;

  assign sif.in_ready  = w_in_ready;
  assign sif.out_valid = r_out_valid;
  assign sif.out_data  = r_out_data;
  assign mem_write_en  = w_write;
  assign mem_address   = w_fetch ? r_rd_ptr : r_wr_ptr;
  assign mem_data_in   = sif.in_data;
  assign count         = r_mem_count + {{ADDR_WIDTH{1'b0}}, r_out_valid};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_count <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_flush) begin
      // out_data is deliberately kept; only occupancy is cleared.
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_count <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_fetch) begin
        r_out_data  <= mem_data_out;
        r_out_valid <= 1'b1;
        r_rd_ptr    <= r_rd_ptr + ADDR_WIDTH'(1);
        r_mem_count <= r_mem_count - (ADDR_WIDTH+1)'(1);
      end else if (w_bypass && sif.in_valid) begin
        r_out_data  <= sif.in_data;
        r_out_valid <= 1'b1;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end

      if (w_write) begin
        r_wr_ptr    <= r_wr_ptr + ADDR_WIDTH'(1);
        r_mem_count <= r_mem_count + (ADDR_WIDTH+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Randomized scoreboard bench for sram_fifo_ctrl with a behavioural SRAM and a queue-based reference FIFO.
module tb_sram_fifo_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  sram_fifo_ctrl_if #(.DATA_WIDTH(DW)) sif ();
  logic [AW:0]   count;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;
  logic          mem_write_en;

  sram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef SRAM_FIFO_FLUSH_EN
    .flush        (flush),
`endif
    .sif          (sif.slave),
    .count        (count),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_write_en (mem_write_en),
    .mem_data_out (mem_data_out)
  );

  // Behavioural single_SRAM: synchronous write, asynchronous read.
  logic [DW-1:0] sram [DEPTH];
  always @(posedge clk) if (mem_write_en) sram[mem_address] <= mem_data_in;
  assign mem_data_out = sram[mem_address];

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];
  int  wr_idx    = 0;
  int  pops_seen = 0;
  bit  wen_seen  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: the reference FIFO is the queue. Occupancy, head and in_ready all follow from its size.
  always @(negedge clk) begin
    int occ;
    int memc;
    bit pop;
    bit slot;
    bit byp;
    bit exp_rdy;
    bit push;
    if (reset) begin
      exp_q.delete();
      wr_idx = 0;
      chk("rst_count", 32'(count), 0);
      chk("rst_out_valid", 32'(sif.out_valid), 0);
      chk("rst_in_ready", 32'(sif.in_ready), 0);
      chk("rst_wen", 32'(mem_write_en), 0);
    end else begin
      occ  = exp_q.size();
      memc = (occ == 0) ? 0 : occ - 1;
      pop  = (occ != 0) && sif.out_ready;
      slot = (occ == 0) || pop;
      byp  = slot && (memc == 0);
      if (flush)     exp_rdy = 0;
      else if (slot) exp_rdy = (memc == 0);
      else           exp_rdy = (memc < DEPTH);
      push = sif.in_valid && exp_rdy;
      chk("count", 32'(count), occ);
      chk("out_valid", 32'(sif.out_valid), 32'(occ != 0));
      chk("in_ready", 32'(sif.in_ready), 32'(exp_rdy));
      chk("mem_wen", 32'(mem_write_en), 32'(push && !byp && !flush));
      chk("mem_data_in", 32'(mem_data_in), 32'(sif.in_data));
      if (mem_write_en) begin
        wen_seen = 1;
        chk("wr_addr", 32'(mem_address), wr_idx % DEPTH);
      end
      if (flush) begin
        exp_q.delete();
        wr_idx = 0;
      end else begin
        if (pop) begin
          chk("out_data", 32'(sif.out_data), 32'(exp_q[0]));
          void'(exp_q.pop_front());
          pops_seen++;
        end
        if (push) begin
          exp_q.push_back(sif.in_data);
          if (!byp) wr_idx++;
        end
      end
    end
  end

  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit r);
    @(posedge clk);
    #1;
    sif.in_valid  = v;
    sif.in_data   = d;
    sif.out_ready = r;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    sif.in_valid  = 1'b0;
    sif.in_data   = '0;
    sif.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  initial begin
    int p0;
    logic [DW-1:0] held;
    sif.in_valid  = 1'b0;
    sif.in_data   = '0;
    sif.out_ready = 1'b0;
    do_reset();
    wen_seen = 0;

    // Single push into an empty FIFO goes through bypass.
    cyc(1, 8'hA5, 0);
    cyc(0, 8'h00, 0);
    @(negedge clk);
    chk("bypass_data", 32'(sif.out_data), 32'h A5);
    chk("bypass_count", 32'(count), 1);
    repeat (3) cyc(0, 8'h00, 0);
    chk("bypass_no_write", 32'(wen_seen), 0);

    // Fill to DEPTH+1, then hold an extra push.
    do_reset();
    for (int i = 0; i < 17; i++) cyc(1, 8'(i), 0);
    cyc(1, 8'h11, 0);
    @(negedge clk);
    chk("full_count", 32'(count), 17);
    chk("full_in_ready", 32'(sif.in_ready), 0);
    repeat (2) cyc(1, 8'h11, 0);

    // Drain at full throughput; the held push lands once the SRAM is empty.
    cyc(1, 8'h11, 1);
    p0 = pops_seen;
    repeat (17) @(posedge clk);
    #1;
    sif.in_valid = 1'b0;
    chk("drain_pops", 32'(pops_seen - p0), 17);
    repeat (3) cyc(0, 8'h00, 1);

    // Random traffic exercises pointer wrap and starvation behaviour.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 99) < 55);
    for (int i = 0; i < 40; i++) cyc(1, 8'(8'h40 + i), 1);
    repeat (25) cyc(0, 8'h00, 1);
    @(negedge clk);
    chk("drained_count", 32'(count), 0);

    // Asynchronous reset mid-stream.
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1, 8'(8'h80 + i), 0);
    cyc(0, 8'h00, 0);
    @(negedge clk);
    chk("pre_reset_count", 32'(count), 9);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_out_valid", 32'(sif.out_valid), 0);
    chk("async_count", 32'(count), 0);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    cyc(1, 8'h3C, 0);
    cyc(0, 8'h00, 1);
    @(negedge clk);
    chk("post_reset_head", 32'(sif.out_data), 32'h3C);
    repeat (3) cyc(0, 8'h00, 1);

`ifdef SRAM_FIFO_FLUSH_EN
    // Flush wins over a same-cycle push.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h60 + i), 0);
    cyc(0, 8'h00, 0);
    @(negedge clk);
    chk("pre_flush_count", 32'(count), 5);
    held = sif.out_data;
    @(posedge clk);
    #1;
    flush = 1'b1;
    sif.in_valid = 1'b1;
    sif.in_data  = 8'h77;
    @(negedge clk);
    chk("flush_in_ready", 32'(sif.in_ready), 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    sif.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_count", 32'(count), 0);
    chk("flush_out_valid", 32'(sif.out_valid), 0);
    chk("flush_out_data_held", 32'(sif.out_data), 32'(held));
    cyc(1, 8'h5A, 0);
    cyc(0, 8'h00, 1);
    @(negedge clk);
    chk("post_flush_head", 32'(sif.out_data), 32'h5A);
    repeat (2) cyc(0, 8'h00, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
